regfile_we_decoder: RTL
=======================

// Module: regfile_we_decoder
// PURPOSE
//  Registered one-hot decoder that turns a 4-bit register index into a 16-bit write-enable strobe.
//  It drives the register file write ports from the writeback stage.
//  It also contains a sweep sequencer that strobes all 16 outputs in order, so that every register can be cleared after reset or on request.
// PARAMETERS
//  SEL_WIDTH       4   index width; legal range 1..6; OUT_WIDTH = 2**SEL_WIDTH (localparam)
//  CLEAR_ON_RESET  1   1: reset leaves the FSM in SWEEP (auto-clear); 0: reset leaves it in IDLE
// PORTS
//  I_CLK     in   1          single clock; all state updates on rising edge
//  I_RESET   in   1          asynchronous, active-high reset
//  I_VALID   in   1          decode request valid
//  I_SEL     in   SEL_WIDTH  index to decode; sampled when a transfer occurs
//  I_ENABLE  in   1          1: strobe the selected output; 0: consume the request, output all-zero
//  I_CLEAR   in   1          start a sweep; sampled in IDLE only
//  O_READY   out  1          combinational: (state==IDLE) && !I_CLEAR
//  O_DATA    out  OUT_WIDTH  registered one-hot write-enable strobe, or zero
//  O_INDEX   out  SEL_WIDTH  registered index of the last decode or sweep step
//  O_BUSY    out  1          registered; 1 while the FSM is in SWEEP
//  O_DONE    out  1          registered; one-cycle pulse on the final sweep step
// BEHAVIOUR
//  Reset (async, immediate):
//   - O_DATA=0, O_INDEX=0, O_DONE=0, sweep counter cnt=0.
//   - state = SWEEP if CLEAR_ON_RESET else IDLE; O_BUSY = CLEAR_ON_RESET.
//  FSM states: IDLE, SWEEP.
//  IDLE:
//   - Transfer = I_VALID && O_READY.
//   - On a transfer, at the next edge: O_INDEX<=I_SEL; O_DATA<=(I_ENABLE ? 1<<I_SEL : 0).
//   - Latency is 1 cycle. Each strobe lasts exactly one cycle.
//   - With no transfer, O_DATA<=0 and O_INDEX holds.
//   - Back-to-back transfers produce one strobe per cycle with no bubble.
//   - I_CLEAR has priority over I_VALID. O_READY is low that cycle, so a simultaneous request is not consumed and must be held by the requester.
//   - On I_CLEAR: state<=SWEEP, cnt<=0, O_DATA<=0, O_BUSY<=1.
//  SWEEP:
//   - Each edge: O_DATA<=1<<cnt, O_INDEX<=cnt, cnt<=cnt+1.
//   - When cnt==OUT_WIDTH-1: O_DONE<=1, O_BUSY<=0, state<=IDLE, and cnt wraps to 0.
//   - I_ENABLE, I_SEL and I_CLEAR are ignored during SWEEP; no restart. O_READY=0.
//   - Timing: bit 0 appears on the 1st edge after entry and bit OUT_WIDTH-1 on the OUT_WIDTH-th edge, together with O_DONE.
//   - O_READY goes high in the same cycle O_DONE is high, so a request can be accepted immediately.
//  Invariants:
//   - O_DATA is always zero or one-hot.
//   - When O_DATA is nonzero, O_DATA == 1<<O_INDEX.
//   - O_DONE is never high for 2 consecutive cycles.
//  Reset mid-sweep: outputs zero immediately. After release, the sweep restarts from bit 0 (CLEAR_ON_RESET=1) or the FSM is IDLE (0).
// TESTING
//  1. CLEAR_ON_RESET=1, release I_RESET -> O_DATA = 0x0001,0x0002,...,0x8000 on 16 consecutive cycles; O_DONE only with 0x8000; O_BUSY=1 during the sweep; O_READY=1 in the cycle O_DONE is high.
//  2. IDLE, I_VALID=1, I_ENABLE=1, I_SEL=4'hA for 1 cycle -> next cycle O_DATA=0x0400, O_INDEX=10; the cycle after, O_DATA=0x0000.
//  3. I_VALID held with I_SEL=0,F,7 on 3 consecutive cycles -> O_DATA=0x0001,0x8000,0x0080 on 3 consecutive cycles.
//  4. I_VALID=1, I_ENABLE=0, I_SEL=3 -> O_DATA stays 0x0000, O_INDEX=3, O_READY stays 1.
//  5. I_CLEAR=1 with I_VALID=1, I_SEL=5 held -> O_READY=0; full sweep runs; 0x0020 appears the cycle after the O_DONE cycle.
//  6. Assert I_RESET while O_DATA=0x0040 mid-sweep -> O_DATA=0 and O_DONE=0 without a clock edge; after release the sequence restarts at 0x0001.

Source files
------------

// File: rtl/regfile_we_decoder.sv
// Registered one-hot write-enable decoder for the register file writeback port,
// with a sweep sequencer that strobes every output in order to clear all registers.
module regfile_we_decoder #(
  parameter int SEL_WIDTH      = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic                        I_VALID,
  input  logic [SEL_WIDTH-1:0]        I_SEL,
  input  logic                        I_ENABLE,
  input  logic                        I_CLEAR,
  output logic                        O_READY,
  output logic [(2**SEL_WIDTH)-1:0]   O_DATA,
  output logic [SEL_WIDTH-1:0]        O_INDEX,
  output logic                        O_BUSY,
  output logic                        O_DONE
);

  localparam int                   OUT_WIDTH = 2**SEL_WIDTH;
  localparam logic [SEL_WIDTH-1:0] CNT_LAST  = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SEL_WIDTH-1:0]   r_cnt;
  logic [SEL_WIDTH-1:0]   w_cnt_nxt;
  logic [OUT_WIDTH-1:0]   r_data;
  logic [OUT_WIDTH-1:0]   w_data_nxt;
  logic [SEL_WIDTH-1:0]   r_index;
  logic [SEL_WIDTH-1:0]   w_index_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   w_ready;

  function automatic logic [OUT_WIDTH-1:0] onehot(input logic [SEL_WIDTH-1:0] sel);
    logic [OUT_WIDTH-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // A clear request masks ready so a simultaneous decode request stays pending.
  assign w_ready = (r_state == ST_IDLE) && !I_CLEAR;

  // Next-state and next-output decode for the IDLE/SWEEP sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = '0;
    w_index_nxt = r_index;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (I_CLEAR) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else if (I_VALID) begin
          w_index_nxt = I_SEL;
          w_data_nxt  = I_ENABLE ? onehot(I_SEL) : '0;
        end else begin
          w_data_nxt  = '0;
        end
      end
      ST_SWEEP: begin
        w_data_nxt  = onehot(r_cnt);
        w_index_nxt = r_cnt;
        if (r_cnt == CNT_LAST) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + SEL_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset optionally starts an auto-clear sweep.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state <= CLEAR_ON_RESET ? ST_SWEEP : ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_index <= '0;
      r_busy  <= CLEAR_ON_RESET;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_index <= w_index_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign O_READY = w_ready;
  assign O_DATA  = r_data;
  assign O_INDEX = r_index;
  assign O_BUSY  = r_busy;
  assign O_DONE  = r_done;

endmodule
